// File: rtl/buf_arb_pkg.sv
// rtl/buf_arb_pkg.sv - shared defaults and requester-id type for the buffer arbiter
package buf_arb_pkg;

  localparam int NREQ_DEFAULT  = 4;
  localparam int NBUF_DEFAULT  = 16;
  localparam int AW_DEFAULT    = 4;
  localparam int QUOTA_DEFAULT = 8;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int RID_W = id_width(NREQ_DEFAULT);
  typedef logic [RID_W-1:0] req_id_t;

endpackage

// File: rtl/buffer_arbiter_rr_pick.sv
// rtl/buffer_arbiter_rr_pick.sv - combinational round-robin picker starting after ptr
module rr_pick
  import buf_arb_pkg::*;
#(
  parameter int N  = NREQ_DEFAULT,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin : pick
    int c;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    c      = 0;
    // Scan ptr+1 .. ptr+N so the last winner has the lowest priority.
    for (int i = 1; i <= N; i++) begin
      c = (int'(ptr) + i) % N;
      if (!any && req[c]) begin
        any       = 1'b1;
        onehot[c] = 1'b1;
        idx       = IW'(c);
      end
    end
  end

endmodule

// File: rtl/buffer_arbiter.sv
// rtl/buffer_arbiter.sv - round-robin alloc/free arbiter in front of a shared buffer allocator
module buffer_arbiter
  import buf_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEFAULT,
  parameter int NBUF  = NBUF_DEFAULT,
  parameter int AW    = AW_DEFAULT,
  parameter int QUOTA = QUOTA_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_alloc,
  output logic [NREQ-1:0]      gnt,
  output logic [AW-1:0]        gnt_addr,
  input  logic [NREQ-1:0]      req_free,
  input  logic [NREQ*AW-1:0]   req_free_addr,
  output logic [NREQ-1:0]      free_ack,
  output logic [NREQ-1:0]      free_err,
  input  logic                 al_full,
  input  logic [AW-1:0]        al_addr,
  output logic                 al_alloc,
  output logic                 al_free,
  output logic [AW-1:0]        al_free_addr
);

  localparam int IW = id_width(NREQ);
  localparam int HW = $clog2(QUOTA + 1);

  logic [NBUF-1:0] valid_q, valid_d;
  logic [IW-1:0]   owner_q [NBUF];
  logic [IW-1:0]   owner_d [NBUF];
  logic [HW-1:0]   held_q  [NREQ];
  logic [HW-1:0]   held_d  [NREQ];
  logic [IW-1:0]   alloc_ptr_q, alloc_ptr_d;
  logic [IW-1:0]   free_ptr_q, free_ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [AW-1:0]   gnt_addr_q, gnt_addr_d;
  logic [NREQ-1:0] free_ack_q, free_ack_d;
  logic [NREQ-1:0] free_err_q, free_err_d;

  logic [NREQ-1:0] alloc_elig, free_elig;
  logic [NREQ-1:0] alloc_oh, free_oh;
  logic [IW-1:0]   alloc_idx, free_idx;
  logic            alloc_any, free_any;
  logic [AW-1:0]   free_addr;
  logic            free_hit;

  always_comb begin
    alloc_elig = '0;
    for (int r = 0; r < NREQ; r++) begin
      alloc_elig[r] = req_alloc[r] & ~gnt_q[r] & (held_q[r] < HW'(QUOTA));
    end
    free_elig = req_free & ~free_ack_q & ~free_err_q;
  end

  rr_pick #(.N(NREQ), .IW(IW)) u_alloc_pick (
    .req    (alloc_elig),
    .ptr    (alloc_ptr_q),
    .onehot (alloc_oh),
    .idx    (alloc_idx),
    .any    (alloc_any)
  );

  rr_pick #(.N(NREQ), .IW(IW)) u_free_pick (
    .req    (free_elig),
    .ptr    (free_ptr_q),
    .onehot (free_oh),
    .idx    (free_idx),
    .any    (free_any)
  );

  always_comb begin
    free_addr    = req_free_addr[free_idx*AW +: AW];
    free_hit     = free_any & valid_q[free_addr] & (owner_q[free_addr] == free_idx);
    // Strobes are gated by reset so the allocator never moves during reset.
    al_alloc     = alloc_any & ~al_full & ~reset;
    al_free      = free_hit & ~reset;
    al_free_addr = free_addr;

    valid_d     = valid_q;
    owner_d     = owner_q;
    alloc_ptr_d = alloc_ptr_q;
    free_ptr_d  = free_ptr_q;
    gnt_d       = '0;
    gnt_addr_d  = '0;
    free_ack_d  = '0;
    free_err_d  = '0;

    if (al_alloc) begin
      gnt_d              = alloc_oh;
      gnt_addr_d         = al_addr;
      alloc_ptr_d        = alloc_idx;
      valid_d[al_addr]   = 1'b1;
      owner_d[al_addr]   = alloc_idx;
    end

    if (free_any) begin
      free_ptr_d = free_idx;
      if (free_hit) begin
        free_ack_d         = free_oh;
        valid_d[free_addr] = 1'b0;
      end else begin
        free_err_d = free_oh;
      end
    end

    // A grant and an ack to the same requester cancel out.
    for (int r = 0; r < NREQ; r++) begin
      held_d[r] = held_q[r] + HW'(gnt_d[r]) - HW'(free_ack_d[r]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q     <= '0;
      alloc_ptr_q <= IW'(NREQ - 1);
      free_ptr_q  <= IW'(NREQ - 1);
      gnt_q       <= '0;
      gnt_addr_q  <= '0;
      free_ack_q  <= '0;
      free_err_q  <= '0;
      for (int b = 0; b < NBUF; b++) owner_q[b] <= '0;
      for (int r = 0; r < NREQ; r++) held_q[r] <= '0;
    end else begin
      valid_q     <= valid_d;
      owner_q     <= owner_d;
      held_q      <= held_d;
      alloc_ptr_q <= alloc_ptr_d;
      free_ptr_q  <= free_ptr_d;
      gnt_q       <= gnt_d;
      gnt_addr_q  <= gnt_addr_d;
      free_ack_q  <= free_ack_d;
      free_err_q  <= free_err_d;
    end
  end

  assign gnt      = gnt_q;
  assign gnt_addr = gnt_addr_q;
  assign free_ack = free_ack_q;
  assign free_err = free_err_q;

endmodule

// File: tb/tb_buffer_arbiter.sv
// tb/tb_buffer_arbiter.sv - directed table-driven bench for buffer_arbiter
module tb_buffer_arbiter;
  import buf_arb_pkg::*;

  logic        clock;
  logic        reset;
  logic [3:0]  req_alloc;
  logic [3:0]  gnt;
  logic [3:0]  gnt_addr;
  logic [3:0]  req_free;
  logic [15:0] req_free_addr;
  logic [3:0]  free_ack;
  logic [3:0]  free_err;
  logic        al_full;
  logic [3:0]  al_addr;
  logic        al_alloc;
  logic        al_free;
  logic [3:0]  al_free_addr;

  logic        force_full;
  logic [15:0] used_q;
  logic [3:0]  model_addr;
  logic        model_full;

  int n_tests = 0;
  int n_fail  = 0;

  buffer_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .req_alloc     (req_alloc),
    .gnt           (gnt),
    .gnt_addr      (gnt_addr),
    .req_free      (req_free),
    .req_free_addr (req_free_addr),
    .free_ack      (free_ack),
    .free_err      (free_err),
    .al_full       (al_full),
    .al_addr       (al_addr),
    .al_alloc      (al_alloc),
    .al_free       (al_free),
    .al_free_addr  (al_free_addr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference allocator: lowest free address, reset in the same domain.
  always @(posedge clock or posedge reset) begin
    if (reset) used_q <= '0;
    else begin
      if (al_alloc) used_q[al_addr] <= 1'b1;
      if (al_free)  used_q[al_free_addr] <= 1'b0;
    end
  end

  always_comb begin
    model_addr = '0;
    for (int b = 15; b >= 0; b--) if (!used_q[b]) model_addr = 4'(b);
    model_full = &used_q;
  end

  assign al_full = model_full | force_full;
  assign al_addr = model_addr;

  typedef struct {
    logic        rst;
    logic [3:0]  ra;
    logic [3:0]  rf;
    logic [15:0] rfa;
    logic        ff;
    logic        ea;
    logic        ef;
    logic [3:0]  fa;
    logic [3:0]  g;
    logic [3:0]  ga;
    logic [3:0]  ack;
    logic [3:0]  err;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic rst, input logic [3:0] ra, input logic [3:0] rf,
                              input logic [15:0] rfa, input logic ff, input logic ea,
                              input logic ef, input logic [3:0] fa, input logic [3:0] g,
                              input logic [3:0] ga, input logic [3:0] ack, input logic [3:0] err);
    vec_t v;
    v.rst = rst; v.ra = ra; v.rf = rf; v.rfa = rfa; v.ff = ff; v.ea = ea;
    v.ef = ef; v.fa = fa; v.g = g; v.ga = ga; v.ack = ack; v.err = err;
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clock);
    reset = 1'b1;
    req_alloc = '0; req_free = '0; req_free_addr = '0; force_full = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    if (v.rst) reset_dut();
    @(negedge clock);
    req_alloc = v.ra; req_free = v.rf; req_free_addr = v.rfa; force_full = v.ff;
    #1;
    check("al_alloc", idx, 32'(al_alloc), 32'(v.ea));
    check("al_free", idx, 32'(al_free), 32'(v.ef));
    if (v.ef) check("al_free_addr", idx, 32'(al_free_addr), 32'(v.fa));
    @(posedge clock); #1;
    check("gnt", idx, 32'(gnt), 32'(v.g));
    if (v.g != 4'b0) check("gnt_addr", idx, 32'(gnt_addr), 32'(v.ga));
    check("free_ack", idx, 32'(free_ack), 32'(v.ack));
    check("free_err", idx, 32'(free_err), 32'(v.err));
  endtask

  initial begin
    int grants;
    //               rst ra    rf    rfa       ff ea ef fa    g     ga    ack   err
    tbl[0]  = mk(1, 4'hF, 4'h0, 16'h0000, 0, 1, 0, 4'd0, 4'h1, 4'd0, 4'h0, 4'h0);
    tbl[1]  = mk(0, 4'hF, 4'h0, 16'h0000, 0, 1, 0, 4'd0, 4'h2, 4'd1, 4'h0, 4'h0);
    tbl[2]  = mk(0, 4'hF, 4'h0, 16'h0000, 0, 1, 0, 4'd0, 4'h4, 4'd2, 4'h0, 4'h0);
    tbl[3]  = mk(0, 4'hF, 4'h0, 16'h0000, 0, 1, 0, 4'd0, 4'h8, 4'd3, 4'h0, 4'h0);
    tbl[4]  = mk(0, 4'hF, 4'h0, 16'h0000, 0, 1, 0, 4'd0, 4'h1, 4'd4, 4'h0, 4'h0);
    tbl[5]  = mk(0, 4'hF, 4'h0, 16'h0000, 0, 1, 0, 4'd0, 4'h2, 4'd5, 4'h0, 4'h0);
    tbl[6]  = mk(1, 4'h3, 4'h0, 16'h0000, 0, 1, 0, 4'd0, 4'h1, 4'd0, 4'h0, 4'h0);
    tbl[7]  = mk(0, 4'h3, 4'h0, 16'h0000, 0, 1, 0, 4'd0, 4'h2, 4'd1, 4'h0, 4'h0);
    tbl[8]  = mk(0, 4'h1, 4'h0, 16'h0000, 0, 1, 0, 4'd0, 4'h1, 4'd2, 4'h0, 4'h0);
    tbl[9]  = mk(0, 4'h8, 4'h0, 16'h0000, 0, 1, 0, 4'd0, 4'h8, 4'd3, 4'h0, 4'h0);
    tbl[10] = mk(0, 4'h0, 4'h0, 16'h0000, 0, 0, 0, 4'd0, 4'h0, 4'd0, 4'h0, 4'h0);
    tbl[11] = mk(0, 4'h8, 4'h0, 16'h0000, 0, 1, 0, 4'd0, 4'h8, 4'd4, 4'h0, 4'h0);
    tbl[12] = mk(0, 4'h0, 4'h0, 16'h0000, 0, 0, 0, 4'd0, 4'h0, 4'd0, 4'h0, 4'h0);
    tbl[13] = mk(0, 4'h8, 4'h0, 16'h0000, 0, 1, 0, 4'd0, 4'h8, 4'd5, 4'h0, 4'h0);
    tbl[14] = mk(0, 4'h0, 4'h2, 16'h0050, 0, 0, 0, 4'd0, 4'h0, 4'd0, 4'h0, 4'h2);
    tbl[15] = mk(0, 4'h0, 4'h8, 16'h5000, 0, 0, 1, 4'd5, 4'h0, 4'd0, 4'h8, 4'h0);
    tbl[16] = mk(0, 4'h1, 4'h1, 16'h0002, 0, 1, 1, 4'd2, 4'h1, 4'd5, 4'h1, 4'h0);
    tbl[17] = mk(0, 4'h0, 4'h0, 16'h0000, 0, 0, 0, 4'd0, 4'h0, 4'd0, 4'h0, 4'h0);
    tbl[18] = mk(0, 4'h0, 4'h3, 16'h0010, 0, 0, 1, 4'd1, 4'h0, 4'd0, 4'h2, 4'h0);
    tbl[19] = mk(0, 4'h0, 4'h1, 16'h0000, 0, 0, 1, 4'd0, 4'h0, 4'd0, 4'h1, 4'h0);

    reset = 1'b1; force_full = 1'b0;
    req_alloc = 4'hF; req_free = 4'hF; req_free_addr = '0;
    @(posedge clock); #1;
    check("rst_gnt", 0, 32'(gnt), 0);
    check("rst_gnt_addr", 0, 32'(gnt_addr), 0);
    check("rst_free_ack", 0, 32'(free_ack), 0);
    check("rst_free_err", 0, 32'(free_err), 0);
    check("rst_al_alloc", 0, 32'(al_alloc), 0);
    check("rst_al_free", 0, 32'(al_free), 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) apply(tbl[i], i);
    check("held0", 0, 32'(dut.held_q[0]), 1);
    check("held1", 1, 32'(dut.held_q[1]), 0);
    check("held3", 3, 32'(dut.held_q[3]), 2);

    // Reset while a grant decision is pending.
    @(negedge clock);
    req_alloc = 4'h3; req_free = '0;
    #1 check("e_al_alloc", 0, 32'(al_alloc), 1);
    @(posedge clock); #1;
    check("e_gnt", 0, 32'(gnt), 32'h2);
    check("e_gnt_addr", 0, 32'(gnt_addr), 0);
    check("e_pending", 0, 32'(al_alloc), 1);
    #1 reset = 1'b1;
    #1;
    check("e_async_gnt", 0, 32'(gnt), 0);
    check("e_async_al_alloc", 0, 32'(al_alloc), 0);
    @(posedge clock); #1;
    check("e_gnt_held", 0, 32'(gnt), 0);
    check("e_valid", 0, 32'(dut.valid_q), 0);
    @(negedge clock);
    reset = 1'b0;
    #1 check("e_al_alloc2", 0, 32'(al_alloc), 1);
    @(posedge clock); #1;
    check("e_gnt2", 0, 32'(gnt), 32'h1);
    check("e_gnt_addr2", 0, 32'(gnt_addr), 0);

    // Quota: requester 2 alone.
    reset_dut();
    grants = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      req_alloc = 4'h4;
      @(posedge clock); #1;
      if (gnt == 4'h4) begin
        check("quota_addr", grants, 32'(gnt_addr), 32'(grants));
        grants++;
      end else begin
        check("quota_idle", c, 32'(gnt), 0);
      end
    end
    check("quota_grants", 0, 32'(grants), 8);
    @(negedge clock);
    req_free = 4'h4; req_free_addr = 16'h0300;
    #1;
    check("quota_al_free", 0, 32'(al_free), 1);
    check("quota_al_alloc", 0, 32'(al_alloc), 0);
    check("quota_free_addr", 0, 32'(al_free_addr), 3);
    @(posedge clock); #1;
    check("quota_ack", 0, 32'(free_ack), 32'h4);
    @(negedge clock);
    req_free = '0;
    #1 check("quota_al_alloc9", 0, 32'(al_alloc), 1);
    @(posedge clock); #1;
    check("quota_gnt9", 0, 32'(gnt), 32'h4);
    check("quota_addr9", 0, 32'(gnt_addr), 3);

    // Allocator full holds requests without a grant.
    reset_dut();
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      force_full = 1'b1; req_alloc = 4'h1;
      #1 check("full_al_alloc", c, 32'(al_alloc), 0);
      @(posedge clock); #1;
      check("full_gnt", c, 32'(gnt), 0);
    end
    @(negedge clock);
    force_full = 1'b0;
    #1 check("unfull_al_alloc", 0, 32'(al_alloc), 1);
    @(posedge clock); #1;
    check("unfull_gnt", 0, 32'(gnt), 32'h1);
    check("unfull_addr", 0, 32'(gnt_addr), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/buffer_arbiter.md
BUFFER_ARBITER -- requirements
Module: buffer_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters.
REQ-002 Parameter NBUF, default 16, number of buffers in the shared allocator.
REQ-003 Parameter AW, default 4, buffer address width (log2 NBUF).
REQ-004 Parameter QUOTA, default 8, maximum buffers held per requester.
REQ-005 clock  in  1  sole clock; all state updates on posedge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req_alloc  in  NREQ  level allocation request per requester, held until granted.
REQ-008 gnt  out  NREQ  registered one-hot grant pulse, one cycle.
REQ-009 gnt_addr  out  AW  buffer address for the granted requester, valid only with gnt.
REQ-010 req_free  in  NREQ  level free request per requester, held until acked.
REQ-011 req_free_addr  in  NREQ*AW  per-requester free address, slice r belongs to requester r.
REQ-012 free_ack  out  NREQ  registered one-hot free-acknowledge pulse.
REQ-013 free_err  out  NREQ  registered pulse: free rejected, buffer not owned by that requester.
REQ-014 al_full  in  1  allocator has no free buffer.
REQ-015 al_addr  in  AW  allocator's lowest free address, combinational.
REQ-016 al_alloc  out  1  combinational allocate strobe to the allocator.
REQ-017 al_free  out  1  combinational free strobe to the allocator.
REQ-018 al_free_addr  out  AW  address to free, valid with al_free.

Function
REQ-019 A requester is alloc-eligible iff req_alloc[r]=1, gnt[r]=0 and held[r] < QUOTA.
REQ-020 When an eligible requester exists and al_full=0, the block SHALL assert al_alloc and select a winner round-robin, starting at alloc_ptr+1 modulo NREQ.
REQ-021 At the next edge, gnt[winner]=1 and gnt_addr=al_addr as sampled in the decision cycle; alloc_ptr=winner; owner[al_addr]=winner; valid[al_addr]=1; held[winner]+1. Latency: request in cycle t -> gnt in cycle t+1.
REQ-022 When al_full=1, no al_alloc and no gnt; requests remain pending with no nack.
REQ-023 A requester is free-eligible iff req_free[r]=1 and free_ack[r]=0 and free_err[r]=0; one free is serviced per cycle, round-robin from free_ptr+1.
REQ-024 Serviced free with valid[a]=1 and owner[a]=r: al_free=1, al_free_addr=a; next edge: free_ack[r]=1, valid[a]=0, held[r]-1, free_ptr=r.
REQ-025 Serviced free failing the ownership check: al_free=0; next edge: free_err[r]=1, free_ptr=r, no table change.
REQ-026 Alloc and free SHALL proceed in the same cycle independently; full is evaluated on the pre-free state, so a free never enables a grant in the same cycle.
REQ-027 If one requester receives a grant and a free ack in the same edge, held[r] SHALL be unchanged.
REQ-028 held[r] is clog2(QUOTA+1) bits wide, saturating at neither end by construction (REQ-019 and REQ-024 guarantee range).
REQ-029 At most one bit of gnt and one bit of free_ack|free_err SHALL be set per cycle.

Reset
REQ-030 On reset assertion, gnt, gnt_addr, free_ack and free_err SHALL be 0 immediately, regardless of clock.
REQ-031 Reset SHALL clear valid[] and held[], and set alloc_ptr and free_ptr to NREQ-1 so requester 0 has first priority.
REQ-032 al_alloc and al_free SHALL be 0 while reset is high.
REQ-033 Reset mid-transaction discards pending grants; the allocator SHALL be reset in the same domain.

Structure
REQ-034 Package buf_arb_pkg SHALL hold NREQ, NBUF, AW and QUOTA defaults, plus the requester-id type (clog2 NREQ bits).
REQ-035 Sub-module rr_pick (request vector and pointer in, one-hot and index out, combinational) SHALL be instantiated twice: once for alloc, once for free.

Verification
REQ-036 After reset, req_alloc=4'b1111 with al_addr following a model allocator -> gnt order 0,1,2,3,0... with addresses 0,1,2,3,...
REQ-037 QUOTA=8, requester 2 alone requests 9 times -> 8 grants, then no grant while held[2]=8; after one ack'd free -> 9th grant.
REQ-038 al_full=1 with req_alloc=4'b0001 -> no al_alloc or gnt; drop al_full -> gnt[0] the next cycle.
REQ-039 Requester 1 frees address 5, owned by requester 3 -> free_err[1]=1, al_free never asserted, valid[5] still 1.
REQ-040 Same cycle: requester 0 allocates and requester 0 frees its buffer 2 -> gnt[0] and free_ack[0] on the same edge, held[0] unchanged, al_alloc=al_free=1.
REQ-041 Assert reset between grant decision and edge -> gnt stays 0, owner table empty, next grant goes to requester 0.
